fetch_pc_unit: RTL



---
 rtl/fetch_pc_unit.sv | 94 +++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
// Fetch next-PC generator: fetch PC register, direct-mapped BTB, BHT index
// and EX-stage misprediction recovery with a saturating mispredict counter.
module fetch_pc_unit #(
   parameter int                  PC_WIDTH  = 32,
   parameter int                  BTB_IDX_W = 4,
   parameter int                  BHT_IDX_W = 4,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   output logic [BHT_IDX_W-1:0] bht_index,
   input  logic                 bht_pred,
   output logic [PC_WIDTH-1:0]  pc,
   output logic                 pred_taken,
   output logic [PC_WIDTH-1:0]  pred_target,
   input  logic                 ex_valid,
   input  logic [PC_WIDTH-1:0]  ex_pc,
   input  logic                 ex_taken,
   input  logic [PC_WIDTH-1:0]  ex_target,
   input  logic                 ex_pred_taken,
   input  logic [PC_WIDTH-1:0]  ex_pred_target,
   output logic                 flush,
   output logic [15:0]          mispred_cnt
);

   localparam int BTB_N = 1 << BTB_IDX_W;
   localparam int TAG_W = PC_WIDTH - BTB_IDX_W - 2;

   logic [PC_WIDTH-1:0]  pc_q, pc_d;
   logic [15:0]          cnt_q, cnt_d;
   logic [BTB_N-1:0]     valid_q, valid_d;
   logic [TAG_W-1:0]     tag_q    [BTB_N];
   logic [TAG_W-1:0]     tag_d    [BTB_N];
   logic [PC_WIDTH-1:0]  target_q [BTB_N];
   logic [PC_WIDTH-1:0]  target_d [BTB_N];

   logic [BTB_IDX_W-1:0] rd_idx, wr_idx;
   logic [TAG_W-1:0]     rd_tag, wr_tag;
   logic                 hit;
   logic [PC_WIDTH-1:0]  pc_plus4, ex_pc_plus4;

   assign rd_idx      = pc_q[BTB_IDX_W+1:2];
   assign rd_tag      = pc_q[PC_WIDTH-1:BTB_IDX_W+2];
   assign wr_idx      = ex_pc[BTB_IDX_W+1:2];
   assign wr_tag      = ex_pc[PC_WIDTH-1:BTB_IDX_W+2];
   assign pc_plus4    = pc_q + PC_WIDTH'(4);
   assign ex_pc_plus4 = ex_pc + PC_WIDTH'(4);

   // Lookup reads registered state only, so a same-cycle write is not seen.
   assign hit         = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign pred_taken  = hit && bht_pred;
   assign pred_target = pred_taken ? target_q[rd_idx] : pc_plus4;
   assign bht_index   = pc_q[BHT_IDX_W+1:2];
   assign pc          = pc_q;
   assign mispred_cnt = cnt_q;

   assign flush = ex_valid && ((ex_taken != ex_pred_taken) ||
                               (ex_taken && (ex_target != ex_pred_target)));

   always_comb begin
      pc_d = pred_target;
      if (flush)      pc_d = ex_taken ? ex_target : ex_pc_plus4;
      else if (stall) pc_d = pc_q;

      cnt_d = cnt_q;
      if (flush && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;

      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      if (ex_valid && ex_taken) begin
         valid_d[wr_idx]  = 1'b1;
         tag_d[wr_idx]    = wr_tag;
         target_d[wr_idx] = ex_target;
      end
   end

   // Reset wins over everything, which also drops any BTB write that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         cnt_q   <= '0;
         valid_q <= '0;
      end else begin
         pc_q     <= pc_d;
         cnt_q    <= cnt_d;
         valid_q  <= valid_d;
         tag_q    <= tag_d;
         target_q <= target_d;
      end
   end

endmodule
